// File: rtl/mem_pkg.sv
// mem_pkg: shared types and byte-enable helper for the MEM stage
// Holds the memory-op, access-size and FSM-state enums plus be_gen(),
// which turns an access size and a lane offset into an 8-bit byte mask.
package mem_pkg;

    typedef enum logic [1:0] {NONE = 2'b00, LOAD = 2'b01, STORE = 2'b10} mem_op_e;
    typedef enum logic [1:0] {B = 2'b00, H = 2'b01, W = 2'b10, D = 2'b11} mem_size_e;
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10, DRAIN = 2'b11} mem_state_e;

    function automatic logic [7:0] be_gen(input mem_size_e size, input logic [2:0] offset);
        logic [7:0] m;
        m = (size == B) ? 8'h01 : (size == H) ? 8'h03 : (size == W) ? 8'h0F : 8'hFF;
        return m << offset;
    endfunction

endpackage

// File: rtl/mem_stage_pl_lane.sv
// mem_lane_align: store lane replication, byte enables and load extraction/extension
// Ports: i_size/i_off/i_uns describe the access, i_wdata is raw store data,
// i_rdata the aligned read bus; o_be, o_wdata drive the memory, o_rdata goes to WB.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OW   = $clog2(NB)
) (
    input  mem_size_e       i_size,
    input  logic [OW-1:0]   i_off,
    input  logic            i_uns,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [NB-1:0]   o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_ext8;
    logic [XLEN-1:0] w_ext16;
    logic [XLEN-1:0] w_ext32;

    assign o_be = NB'(be_gen(i_size, 3'(i_off)));

    assign o_wdata = (i_size == B) ? {NB{i_wdata[7:0]}} :
                     (i_size == H) ? {(NB/2){i_wdata[15:0]}} :
                     (i_size == W) ? {(NB/4){i_wdata[31:0]}} : i_wdata;

    // Bring the addressed lane down to bit 0 before extending it.
    assign w_sh    = i_rdata >> {i_off, 3'b000};
    assign w_ext8  = i_uns ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]));
    assign w_ext16 = i_uns ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
    assign w_ext32 = i_uns ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));

    assign o_rdata = (i_size == B) ? w_ext8 :
                     (i_size == H) ? w_ext16 :
                     (i_size == W) ? w_ext32 : w_sh;

endmodule

// File: rtl/mem_stage_pl.sv
// mem_stage_pl: EX->WB memory-access stage with req/gnt/rvalid handshake
// Inputs *_mem carry the instruction in MEM; d_* is the data-memory port;
// stall_mem holds upstream; *_wb is the MEM/WB register with valid_wb.
module mem_stage_pl
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TRD_W  = 3,
    parameter int REG_W  = 5,
    parameter int SIDE_W = 64,
    parameter int TCTL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_mem,
    input  logic [31:0]         ins_mem,
    input  logic [XLEN-1:0]     pc_mem,
    input  logic [XLEN-1:0]     addr_mem,
    input  logic [XLEN-1:0]     exe_data_mem,
    input  logic [TRD_W-1:0]    trd_mem,
    input  logic [REG_W-1:0]    reg_wr_mem,
    input  logic                wr_en_mem,
    input  logic                wb_sel_mem,
    input  logic [1:0]          mem_op_mem,
    input  logic [1:0]          mem_size_mem,
    input  logic                mem_uns_mem,
    input  logic [TCTL_W-1:0]   trd_ctrl_mem,
    input  logic [TCTL_W-1:0]   obj_trd_mem,
    input  logic [SIDE_W-1:0]   side_mem,
    input  logic                flush_mem,
    output logic                d_req,
    output logic                d_we,
    output logic [XLEN-1:0]     d_addr,
    output logic [XLEN/8-1:0]   d_be,
    output logic [XLEN-1:0]     d_wdata,
    input  logic                d_gnt,
    input  logic                d_rvalid,
    input  logic [XLEN-1:0]     d_rdata,
    output logic                stall_mem,
    output logic                valid_wb,
    output logic [31:0]         ins_wb,
    output logic [XLEN-1:0]     pc_wb,
    output logic [XLEN-1:0]     data_wb,
    output logic [TRD_W-1:0]    trd_wb,
    output logic [REG_W-1:0]    reg_wr_wb,
    output logic                wr_en_wb,
    output logic                wb_sel_wb,
    output logic [TCTL_W-1:0]   trd_ctrl_wb,
    output logic [TCTL_W-1:0]   obj_trd_wb,
    output logic [SIDE_W-1:0]   side_wb,
    output logic                misalign_wb
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    mem_state_e      r_state;
    mem_state_e      w_next;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_we;
    mem_size_e       r_size;

    mem_op_e         w_op;
    mem_size_e       w_size;
    logic            w_go;
    logic            w_is_mem;
    logic            w_aligned;
    logic            w_active;
    logic            w_misalign;
    logic            w_retire;
    logic            w_capture;
    logic            w_use_r;
    logic [XLEN-1:0] w_lane_addr;
    logic [XLEN-1:0] w_lane_wdata;
    mem_size_e       w_lane_size;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ldata;

    assign w_op   = mem_op_e'(mem_op_mem);
    assign w_size = mem_size_e'(mem_size_mem);

    // rst_n folded in so nothing is requested or stalled while reset is held.
    assign w_go       = valid_mem & ~flush_mem & rst_n;
    assign w_is_mem   = w_go & ((w_op == LOAD) | (w_op == STORE));
    assign w_aligned  = (w_size == B) |
                        ((w_size == H) & ~addr_mem[0]) |
                        ((w_size == W) & (addr_mem[1:0] == 2'b00)) |
                        ((w_size == D) & (XLEN == 64) & (addr_mem[2:0] == 3'b000));
    assign w_active   = w_is_mem & w_aligned;
    assign w_misalign = w_is_mem & ~w_aligned;
    assign w_capture  = (r_state == IDLE) & w_active;

    // Once the access is in flight the registered copy drives the port.
    assign w_use_r      = (r_state != IDLE);
    assign w_lane_addr  = w_use_r ? r_addr : addr_mem;
    assign w_lane_wdata = w_use_r ? r_wdata : exe_data_mem;
    assign w_lane_size  = w_use_r ? r_size : w_size;

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .i_size  (w_lane_size),
        .i_off   (w_lane_addr[OW-1:0]),
        .i_uns   (mem_uns_mem),
        .i_wdata (w_lane_wdata),
        .i_rdata (d_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A flush that lands together with d_gnt still counts as granted:
    // the store is already committed, the load response must be drained.
    always_comb begin
        w_next   = r_state;
        d_req    = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            IDLE: begin
                d_req    = w_active;
                w_retire = w_go & (~w_active | (d_gnt & (w_op == STORE)));
                w_next   = ~w_active ? IDLE : ~d_gnt ? REQ : (w_op == LOAD) ? RESP : IDLE;
            end
            REQ: begin
                d_req    = ~flush_mem;
                w_retire = w_go & d_gnt & r_we;
                w_next   = d_gnt ? (r_we ? IDLE : flush_mem ? DRAIN : RESP) : flush_mem ? IDLE : REQ;
            end
            RESP: begin
                w_retire = w_go & d_rvalid;
                w_next   = d_rvalid ? IDLE : flush_mem ? DRAIN : RESP;
            end
            default: begin
                w_next = d_rvalid ? IDLE : DRAIN;
            end
        endcase
    end

    assign stall_mem = (r_state == DRAIN) | (w_go & ~w_retire);
    assign d_we      = d_req & (w_use_r ? r_we : (w_op == STORE));
    assign d_addr    = d_req ? {w_lane_addr[XLEN-1:OW], {OW{1'b0}}} : '0;
    assign d_be      = d_req ? w_be : '0;
    assign d_wdata   = d_req ? w_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= B;
        end else if (w_capture) begin
            r_addr  <= addr_mem;
            r_wdata <= exe_data_mem;
            r_we    <= (w_op == STORE);
            r_size  <= w_size;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_wb    <= 1'b0;
            ins_wb      <= '0;
            pc_wb       <= '0;
            data_wb     <= '0;
            trd_wb      <= '0;
            reg_wr_wb   <= '0;
            wr_en_wb    <= 1'b0;
            wb_sel_wb   <= 1'b0;
            trd_ctrl_wb <= '0;
            obj_trd_wb  <= '0;
            side_wb     <= '0;
            misalign_wb <= 1'b0;
        end else begin
            valid_wb    <= w_retire;
            ins_wb      <= w_retire ? ins_mem : '0;
            pc_wb       <= w_retire ? pc_mem : '0;
            data_wb     <= ~w_retire ? '0 : ((w_op == LOAD) & w_aligned) ? w_ldata : exe_data_mem;
            trd_wb      <= w_retire ? trd_mem : '0;
            reg_wr_wb   <= w_retire ? reg_wr_mem : '0;
            wr_en_wb    <= w_retire & wr_en_mem & ~w_misalign;
            wb_sel_wb   <= w_retire & wb_sel_mem;
            trd_ctrl_wb <= w_retire ? trd_ctrl_mem : '0;
            obj_trd_wb  <= w_retire ? obj_trd_mem : '0;
            side_wb     <= w_retire ? side_mem : '0;
            misalign_wb <= w_retire & w_misalign;
        end
    end

endmodule

// File: tb/tb_mem_stage_pl.sv
// tb_mem_stage_pl: scoreboard bench for mem_stage_pl (XLEN 32 random + XLEN 64 directed)
module tb_mem_stage_pl;

    localparam logic [1:0] LD = 2'b01;
    localparam logic [1:0] ST = 2'b10;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] data;
        logic [2:0]  trd;
        logic [4:0]  rd;
        logic        we;
        logic        sel;
        logic [2:0]  tc;
        logic [2:0]  ot;
        logic [63:0] side;
        logic        mis;
    } wb_t;

    logic        clk, rst_n;
    logic        valid_mem, wr_en_mem, wb_sel_mem, mem_uns_mem, flush_mem;
    logic [31:0] ins_mem, pc_mem, addr_mem, exe_data_mem, d_rdata;
    logic [2:0]  trd_mem, trd_ctrl_mem, obj_trd_mem;
    logic [4:0]  reg_wr_mem;
    logic [1:0]  mem_op_mem, mem_size_mem;
    logic [63:0] side_mem;
    logic        d_gnt, d_rvalid;
    logic        d_req, d_we, stall_mem;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        valid_wb, wr_en_wb, wb_sel_wb, misalign_wb;
    logic [31:0] ins_wb, pc_wb, data_wb;
    logic [2:0]  trd_wb, trd_ctrl_wb, obj_trd_wb;
    logic [4:0]  reg_wr_wb;
    logic [63:0] side_wb;

    logic        q_valid, q_uns, q_gnt, q_rvalid;
    logic [1:0]  q_op, q_size;
    logic [63:0] q_addr, q_rdata;
    logic        q_req, q_we, q_stall, q_vwb, q_wen, q_sel, q_mis;
    logic [63:0] q_daddr, q_wdata, q_pc, q_data;
    logic [7:0]  q_be;
    logic [31:0] q_ins;
    logic [2:0]  q_trd, q_tc, q_ot;
    logic [4:0]  q_rd;
    logic [63:0] q_side;

    int  tests = 0;
    int  fails = 0;
    int  drain_left = 0;
    wb_t sb[$];
    wb_t act, expw;

    mem_stage_pl dut (
        .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .ins_mem(ins_mem), .pc_mem(pc_mem),
        .addr_mem(addr_mem), .exe_data_mem(exe_data_mem), .trd_mem(trd_mem), .reg_wr_mem(reg_wr_mem),
        .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem), .mem_op_mem(mem_op_mem), .mem_size_mem(mem_size_mem),
        .mem_uns_mem(mem_uns_mem), .trd_ctrl_mem(trd_ctrl_mem), .obj_trd_mem(obj_trd_mem), .side_mem(side_mem),
        .flush_mem(flush_mem), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .stall_mem(stall_mem), .valid_wb(valid_wb),
        .ins_wb(ins_wb), .pc_wb(pc_wb), .data_wb(data_wb), .trd_wb(trd_wb), .reg_wr_wb(reg_wr_wb),
        .wr_en_wb(wr_en_wb), .wb_sel_wb(wb_sel_wb), .trd_ctrl_wb(trd_ctrl_wb), .obj_trd_wb(obj_trd_wb),
        .side_wb(side_wb), .misalign_wb(misalign_wb)
    );

    mem_stage_pl #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .valid_mem(q_valid), .ins_mem(32'h0), .pc_mem(64'h0),
        .addr_mem(q_addr), .exe_data_mem(64'h5555), .trd_mem(3'h0), .reg_wr_mem(5'h1),
        .wr_en_mem(1'b1), .wb_sel_mem(1'b1), .mem_op_mem(q_op), .mem_size_mem(q_size),
        .mem_uns_mem(q_uns), .trd_ctrl_mem(3'h0), .obj_trd_mem(3'h0), .side_mem(64'h0),
        .flush_mem(1'b0), .d_req(q_req), .d_we(q_we), .d_addr(q_daddr), .d_be(q_be), .d_wdata(q_wdata),
        .d_gnt(q_gnt), .d_rvalid(q_rvalid), .d_rdata(q_rdata), .stall_mem(q_stall), .valid_wb(q_vwb),
        .ins_wb(q_ins), .pc_wb(q_pc), .data_wb(q_data), .trd_wb(q_trd), .reg_wr_wb(q_rd),
        .wr_en_wb(q_wen), .wb_sel_wb(q_sel), .trd_ctrl_wb(q_tc), .obj_trd_wb(q_ot),
        .side_wb(q_side), .misalign_wb(q_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        act = {ins_wb, pc_wb, data_wb, trd_wb, reg_wr_wb, wr_en_wb, wb_sel_wb, trd_ctrl_wb, obj_trd_wb, side_wb, misalign_wb};
        tests++;
        if (valid_wb) begin
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected got %h want no retire", act);
            end else begin
                expw = sb.pop_front();
                if (act !== expw) begin
                    fails++;
                    $display("FAIL wb_record got %h want %h", act, expw);
                end
            end
        end else if (act !== '0) begin
            fails++;
            $display("FAIL wb_bubble got %h want 0", act);
        end
    end

    // One instruction: gd = grant cycle, rd = grant-to-rvalid distance, fa = flush cycle (-1 none).
    task automatic run(input logic [1:0] op, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] exe, input logic [31:0] rdata, input int gd, input int rd, input int fa);
        int nbytes, off, c, rvc;
        bit is_mem, aligned, active, granted, done, fl, gn, rv, retire, exp_req;
        logic [3:0]  be;
        logic [31:0] wd, ld, ins, pc;
        logic [63:0] v, m, side;
        logic [2:0]  trd, tc, ot;
        logic [4:0]  rdst;
        logic        wen, sel;
        wb_t e;
        ins = $urandom; pc = $urandom; trd = 3'($urandom); tc = 3'($urandom); ot = 3'($urandom);
        rdst = 5'($urandom); wen = 1'($urandom); sel = 1'($urandom); side = {$urandom, $urandom};
        nbytes  = 1 << sz;
        off     = addr % 4;
        is_mem  = (op == LD) || (op == ST);
        aligned = (nbytes <= 4) && (addr % nbytes == 0);
        active  = is_mem && aligned;
        be      = 4'(((1 << nbytes) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = exe[8*(i % nbytes) +: 8];
        v = {32'h0, rdata} >> (8 * off);
        m = (64'd1 << (8 * nbytes)) - 64'd1;
        v = v & m;
        if (!uns && v[8*nbytes-1]) v = v | ~m;
        ld = v[31:0];
        e = {ins, pc, (op == LD && aligned) ? ld : exe, trd, rdst, wen && !(is_mem && !aligned), sel, tc, ot, side, is_mem && !aligned};
        rvc = gd + rd;
        if (fa == rvc) fa = -1;
        c = 0; granted = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            valid_mem = 1'b1; ins_mem = ins; pc_mem = pc; addr_mem = addr; exe_data_mem = exe;
            trd_mem = trd; reg_wr_mem = rdst; wr_en_mem = wen; wb_sel_mem = sel; mem_op_mem = op;
            mem_size_mem = sz; mem_uns_mem = uns; trd_ctrl_mem = tc; obj_trd_mem = ot; side_mem = side;
            if (drain_left > 0) begin
                flush_mem = 1'b0; d_gnt = 1'b0; d_rvalid = (drain_left == 1); d_rdata = $urandom;
                #1;
                chk("drain_req", d_req, 0);
                chk("drain_stall", stall_mem, 1);
                drain_left--;
            end else begin
                fl = (c == fa);
                gn = active && !granted && (c == gd) && (c > 0 || !fl);
                rv = active && (op == LD) && granted && (c == rvc);
                flush_mem = fl; d_gnt = gn; d_rvalid = rv; d_rdata = rv ? rdata : $urandom;
                #1;
                exp_req = active && !granted && !fl;
                chk("d_req", d_req, exp_req);
                if (exp_req) begin
                    chk("d_addr", d_addr, addr & ~32'h3);
                    chk("d_be", d_be, be);
                    chk("d_we", d_we, op == ST);
                    if (op == ST) chk("d_wdata", d_wdata, wd);
                end
                retire = !fl && (!active || (op == ST && gn) || rv);
                chk("stall", stall_mem, !fl && !retire);
                if (retire) sb.push_back(e);
                if (gn) granted = 1;
                if (fl && granted && op == LD) drain_left = rvc - c;
                done = retire || fl;
                c++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_mem = 1'b0; flush_mem = 1'b0; d_gnt = 1'b0; d_rvalid = (drain_left == 1);
            #1;
            chk("idle_stall", stall_mem, drain_left > 0);
            chk("idle_req", d_req, 0);
            if (drain_left > 0) drain_left--;
        end
    endtask

    initial begin
        rst_n = 1'b0; valid_mem = 0; ins_mem = 0; pc_mem = 0; addr_mem = 0; exe_data_mem = 0;
        trd_mem = 0; reg_wr_mem = 0; wr_en_mem = 0; wb_sel_mem = 0; mem_op_mem = 0; mem_size_mem = 0;
        mem_uns_mem = 0; trd_ctrl_mem = 0; obj_trd_mem = 0; side_mem = 0; flush_mem = 0;
        d_gnt = 0; d_rvalid = 0; d_rdata = 0;
        q_valid = 0; q_uns = 0; q_gnt = 0; q_rvalid = 0; q_op = 0; q_size = 0; q_addr = 0; q_rdata = 0;
        #1;
        chk("rst_valid_wb", valid_wb, 0);
        chk("rst_d_req", d_req, 0);
        chk("rst_stall", stall_mem, 0);
        chk("rst_data_wb", data_wb, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run(LD, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h8000_0000, 0, 2, -1);
        run(LD, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h8000_0000, 0, 2, -1);
        run(ST, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 1, -1);
        run(LD, 2'd2, 1'b0, 32'h3001, 32'h7777, 32'h0, 0, 1, -1);
        run(LD, 2'd0, 1'b0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0, 3, 1);
        run(LD, 2'd1, 1'b0, 32'h5002, 32'h0, 32'h8001_0000, 1, 1, -1);
        run(ST, 2'd2, 1'b0, 32'h6000, 32'hCAFE_F00D, 32'h0, 3, 1, 1);
        run(ST, 2'd0, 1'b0, 32'h6001, 32'h0000_00A5, 32'h0, 2, 1, 2);
        run(LD, 2'd2, 1'b0, 32'h6004, 32'h0, 32'h1111_2222, 2, 2, 2);
        run(LD, 2'd3, 1'b0, 32'h7000, 32'h0, 32'h0, 0, 1, -1);
        run(2'b11, 2'd2, 1'b0, 32'h7001, 32'h0BAD, 32'h0, 0, 1, -1);
        run(2'b00, 2'd0, 1'b0, 32'h7002, 32'h0123, 32'h0, 0, 1, -1);
        idle(8);

        for (int k = 0; k < 400; k++) begin
            logic [1:0]  op, sz;
            logic [31:0] a;
            op = 2'($urandom); sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            run(op, sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(8);

        @(negedge clk);
        valid_mem = 1; mem_op_mem = LD; mem_size_mem = 2'd2; addr_mem = 32'h40; flush_mem = 0; d_gnt = 1; d_rvalid = 0;
        #1 chk("midrst_req_before", d_req, 1);
        @(negedge clk);
        d_gnt = 0; rst_n = 0;
        #1;
        chk("midrst_req", d_req, 0);
        chk("midrst_stall", stall_mem, 0);
        chk("midrst_valid_wb", valid_wb, 0);
        @(negedge clk);
        rst_n = 1; valid_mem = 0; d_rvalid = 1; d_rdata = 32'h9999_9999;
        #1 chk("midrst_late_rvalid_stall", stall_mem, 0);
        idle(3);

        @(negedge clk);
        q_valid = 1; q_op = LD; q_size = 2'd3; q_addr = 64'h8; q_gnt = 1;
        #1;
        chk("x64_req", q_req, 1);
        chk("x64_be", q_be, 8'hFF);
        chk("x64_addr", q_daddr, 64'h8);
        @(negedge clk);
        q_gnt = 0; q_rvalid = 1; q_rdata = 64'h0123_4567_89AB_CDEF;
        #1 chk("x64_stall_rvalid", q_stall, 0);
        @(negedge clk);
        q_rvalid = 0; q_size = 2'd2; q_addr = 64'h4; q_gnt = 1;
        #1;
        chk("x64_valid_wb", q_vwb, 1);
        chk("x64_data_wb", q_data, 64'h0123_4567_89AB_CDEF);
        chk("x64_word_be", q_be, 8'hF0);
        @(negedge clk);
        q_gnt = 0; q_rvalid = 1; q_rdata = 64'h8000_0000_0000_0001;
        @(negedge clk);
        q_rvalid = 0; q_size = 2'd3; q_addr = 64'hC;
        #1;
        chk("x64_word_data", q_data, 64'hFFFF_FFFF_8000_0000);
        chk("x64_mis_req", q_req, 0);
        chk("x64_mis_stall", q_stall, 0);
        @(negedge clk);
        q_valid = 0;
        #1;
        chk("x64_mis_valid", q_vwb, 1);
        chk("x64_mis_flag", q_mis, 1);
        chk("x64_mis_wren", q_wen, 0);

        idle(2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_pl.md
Name: mem_stage_pl

Overview:
- Parametrised memory-access pipeline stage between EX and WB for the multithreaded core.
- Adds sub-word loads and stores with byte enables and load sign/zero extension.
- Adds a req/gnt/rvalid data-memory handshake with multi-cycle stall, misalignment detection, and flush-safe abort/drain of outstanding accesses.
- Drives the MEM/WB pipeline register with an explicit valid bit.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- TRD_W, 3: thread-id width.
- REG_W, 5: register-index width.
- SIDE_W, 64: width of the opaque side-band bundle (new_pc/new_data) passed to WB.
- TCTL_W, 3: thread-control field width (trd_ctrl, obj_trd).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- valid_mem  in  1  instruction present in MEM
- ins_mem  in  32  instruction word
- pc_mem  in  XLEN  instruction PC
- addr_mem  in  XLEN  effective address
- exe_data_mem  in  XLEN  ALU result / store data
- trd_mem  in  TRD_W  thread id
- reg_wr_mem  in  REG_W  destination register
- wr_en_mem  in  1  register write enable
- wb_sel_mem  in  1  1 = write back load data, 0 = exe_data
- mem_op_mem  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- mem_size_mem  in  2  00 byte, 01 half, 10 word, 11 dword
- mem_uns_mem  in  1  zero-extend load
- trd_ctrl_mem  in  TCTL_W  thread-control code
- obj_trd_mem  in  TCTL_W  target thread
- side_mem  in  SIDE_W  side-band bundle
- flush_mem  in  1  kill MEM instruction
- d_req  out  1  memory request
- d_we  out  1  1 = store
- d_addr  out  XLEN  address, low log2(XLEN/8) bits zeroed
- d_be  out  XLEN/8  byte enables
- d_wdata  out  XLEN  lane-replicated store data
- d_gnt  in  1  request accepted
- d_rvalid  in  1  load data valid
- d_rdata  in  XLEN  aligned read bus
- stall_mem  out  1  hold upstream stages
- wb fields  out  mirror widths  valid_wb, ins_wb, pc_wb, data_wb, trd_wb, reg_wr_wb, wr_en_wb, wb_sel_wb, trd_ctrl_wb, obj_trd_wb, side_wb, misalign_wb

Behaviour:
- Reset: all outputs and WB registers are 0; FSM is IDLE.
- FSM states:
  - IDLE
  - REQ: request issued, not yet granted
  - RESP: load granted, awaiting data
  - DRAIN: flushed load, discarding its response
- Active access: valid_mem & !flush_mem & op∈{01,10} & aligned.
- IDLE:
  - On an active access: assert d_req combinationally.
  - If d_gnt in the same cycle: a store retires in that cycle; a load goes to RESP.
  - If no d_gnt: go to REQ.
- REQ: hold d_req and all request fields stable until d_gnt.
  - On d_gnt: a store retires; a load goes to RESP.
- RESP: on d_rvalid, the load retires and the FSM returns to IDLE.
  - d_rvalid in the same cycle as gnt is not permitted; the response is one cycle after grant at the earliest.
- stall_mem = valid_mem & !flush_mem & (instruction does not retire this cycle). It is also asserted throughout DRAIN.
- Retire: on the next clk edge the WB register captures all fields with valid_wb = 1.
  - data_wb = extended load data for a load, otherwise exe_data_mem.
- Non-retire cycle: the WB register loads a bubble (all fields 0).
- Non-memory instruction with valid_mem & !flush_mem: retires in 1 cycle with no request.
- Alignment rules:
  - half requires addr[0] = 0.
  - word requires addr[1:0] = 0.
  - dword requires addr[2:0] = 0 and XLEN = 64; dword with XLEN = 32 is misaligned.
  - A misaligned access issues no request and retires in 1 cycle with misalign_wb = 1 and wr_en_wb = 0.
- Byte enables: BE = size mask shifted by addr lane offset.
- Store data: d_wdata replicates the low 8/16/32 bits across all lanes.
- Loads: select the lane by the addr offset, then sign-extend, or zero-extend if mem_uns_mem.
- Flush:
  - flush_mem in IDLE or REQ: d_req drops the same cycle; FSM goes to IDLE; WB gets a bubble.
  - A flush coinciding with d_gnt counts as granted: a load goes to DRAIN, a store is committed in memory but produces a bubble in WB.
  - flush_mem in RESP goes to DRAIN.
  - DRAIN discards the response on d_rvalid and then goes to IDLE. No new request is issued while in DRAIN.
- Request fields (addr, op, size, store data) are registered internally on entry to REQ or RESP. Upstream stalls keep the MEM inputs stable anyway.
- Mid-operation reset: rst_n low forces IDLE immediately and drops d_req. A response arriving after reset release is ignored because the FSM is in IDLE.

Decomposition:
- Package mem_pkg holds:
  - mem_op_e (NONE, LOAD, STORE)
  - mem_size_e (B, H, W, D)
  - mem_state_e (IDLE, REQ, RESP, DRAIN)
  - function be_gen(size, offset)
- One sub-module, mem_lane_align: combinational store replication, BE generation, and load extraction/extension, parametrised by XLEN.

Test Plan:
- Load byte, signed: addr 0x1003, rdata 0x80_00_00_00, gnt at cycle 0, rvalid at cycle 2 → d_be = 1000, stall for 2 cycles, data_wb = 0xFFFFFF80 (0x00000080 when uns = 1).
- Store half: addr 0x2002, exe_data 0x1234ABCD, gnt delayed 3 cycles → d_req and fields stable for 4 cycles, d_be = 1100, d_wdata = 0xABCDABCD, store retires in the gnt cycle.
- Misaligned word: addr 0x3001 → no d_req, misalign_wb = 1, wr_en_wb = 0, no stall.
- Flush in RESP: load granted, flush next cycle, rvalid 2 cycles later with 0xDEADBEEF → the value never reaches WB; the following load issues only after the drain completes.
- Flush in REQ without gnt → d_req drops the same cycle, WB gets a bubble, FSM returns to IDLE.
- XLEN = 64: dword load at addr 0x8 → d_be = 0xFF; the same access with addr 0xC is flagged misaligned.
